// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand carry-save reduction tree with a registered final CPA.
// Each stage is one Dadda height level; the low APPROX_BITS columns can switch to OR-cells per transaction.
module csa_tree_pipe #(
    parameter int WIDTH       = 24,
    parameter int NUM_OPS     = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [NUM_OPS*WIDTH-1:0]          in_data_i,
    input  logic                              in_approx_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [WIDTH+$clog2(NUM_OPS)-1:0]  out_sum_o,
    output logic                              out_approx_o
);

    // Dadda height sequence: 2,3,4,6,9,13,19,28,...
    function automatic int dd(input int k);
        int d;
        d = 2;
        for (int i = 0; i < 16; i++)
            if (i < k) d = (d * 3) / 2;
        return d;
    endfunction

    function automatic int levels_f(input int n);
        int l;
        l = 0;
        for (int i = 15; i >= 0; i--)
            if (dd(i) >= n) l = i;
        return l;
    endfunction

    // Number of rows present at the input of level s (s == lv gives the CPA input).
    function automatic int rh(input int s, input int n, input int lv);
        int h;
        h = n;
        for (int k = 0; k < 16; k++)
            if (k < s && h > dd(lv - 1 - k)) h = dd(lv - 1 - k);
        return h;
    endfunction

    localparam int OUT_W  = WIDTH + $clog2(NUM_OPS);
    localparam int LEVELS = levels_f(NUM_OPS);
    localparam logic [OUT_W-1:0] LO_M = OUT_W'((64'd1 << APPROX_BITS) - 64'd1);

    typedef logic [NUM_OPS-1:0][OUT_W-1:0] bank_t;

    // Bitwise 3:2 row compressor; approximate columns become OR cells with no carry.
    function automatic logic [OUT_W-1:0] csa_sum(input logic [OUT_W-1:0] a, b, c,
                                                 input logic apx);
        logic [OUT_W-1:0] s;
        for (int i = 0; i < OUT_W; i++) begin
            if (apx && i < APPROX_BITS) s[i] = a[i] | b[i] | c[i];
            else                        s[i] = c[i] ? ~(a[i] ^ b[i]) : (a[i] ^ b[i]);
        end
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] csa_cy(input logic [OUT_W-1:0] a, b, c,
                                                input logic apx);
        logic [OUT_W-1:0] cy;
        for (int i = 0; i < OUT_W; i++) begin
            if (apx && i < APPROX_BITS) cy[i] = 1'b0;
            else                        cy[i] = (a[i] ^ b[i]) ? c[i] : a[i];
        end
        return cy << 1;
    endfunction

    logic              adv;
    logic [LEVELS:0]   vld_q;
    logic [LEVELS:0]   apx_q;
    logic [OUT_W-1:0]  sum_q, sum_d;
    bank_t             in_rows;
    bank_t             lv_in  [LEVELS];
    logic              lv_apx [LEVELS];
    bank_t             stg_q  [LEVELS];

    assign adv        = !vld_q[LEVELS] || out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        in_rows = '0;
        for (int k = 0; k < NUM_OPS; k++)
            in_rows[k] = OUT_W'(in_data_i[k*WIDTH +: WIDTH]);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int H = rh(l, NUM_OPS, LEVELS);
        localparam int T = rh(l + 1, NUM_OPS, LEVELS);
        localparam int N = H - T;

        bank_t nxt, q;

        if (l == 0) begin : g_src_in
            assign lv_in[l]  = in_rows;
            assign lv_apx[l] = in_approx_i;
        end else begin : g_src_stg
            assign lv_in[l]  = stg_q[l-1];
            assign lv_apx[l] = apx_q[l-1];
        end

        // N compressors consume the first 3N rows; the remaining rows pass straight through.
        always_comb begin
            nxt = '0;
            for (int j = 0; j < N; j++) begin
                nxt[2*j]   = csa_sum(lv_in[l][3*j], lv_in[l][3*j+1], lv_in[l][3*j+2], lv_apx[l]);
                nxt[2*j+1] = csa_cy (lv_in[l][3*j], lv_in[l][3*j+1], lv_in[l][3*j+2], lv_apx[l]);
            end
            for (int j = 3*N; j < H; j++)
                nxt[j-N] = lv_in[l][j];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   q <= '0;
            else if (adv) q <= nxt;
        end

        assign stg_q[l] = q;
    end

    // Approximate CPA: OR across the low columns, exact add above with no carry-in.
    always_comb begin
        if (apx_q[LEVELS-1])
            sum_d = ((stg_q[LEVELS-1][0] & ~LO_M) + (stg_q[LEVELS-1][1] & ~LO_M))
                  | ((stg_q[LEVELS-1][0] | stg_q[LEVELS-1][1]) & LO_M);
        else
            sum_d = stg_q[LEVELS-1][0] + stg_q[LEVELS-1][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            apx_q <= '0;
            sum_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[LEVELS-1:0], in_valid_i};
            apx_q <= {apx_q[LEVELS-1:0], in_approx_i};
            sum_q <= sum_d;
        end
    end

    assign out_valid_o  = vld_q[LEVELS];
    assign out_approx_o = apx_q[LEVELS];
    assign out_sum_o    = sum_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed and random checks of csa_tree_pipe: latency, exact/approx sums, backpressure, reset, sizing.
module tb_csa_tree_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready, in_approx = 1'b0;
    logic [191:0] in_data = '0;
    logic         out_valid, out_ready = 1'b1, out_approx;
    logic [26:0]  out_sum;

    logic         s3_v = 1'b0, s3_rdy, s3_ov, s3_oa, s3_ordy = 1'b1;
    logic [71:0]  s3_d = '0;
    logic [25:0]  s3_sum;
    logic         s9_v = 1'b0, s9_rdy, s9_ov, s9_oa, s9_ordy = 1'b1;
    logic [215:0] s9_d = '0;
    logic [27:0]  s9_sum;

    int n_chk = 0;
    int n_fail = 0;
    logic [26:0] exp_q [$];
    logic        exp_a [$];

    always #5 clk = ~clk;

    csa_tree_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_approx_i(in_approx), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_sum_o(out_sum), .out_approx_o(out_approx)
    );

    csa_tree_pipe #(.WIDTH(24), .NUM_OPS(3), .APPROX_BITS(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s3_v), .in_ready_o(s3_rdy),
        .in_data_i(s3_d), .in_approx_i(1'b0), .out_valid_o(s3_ov),
        .out_ready_i(s3_ordy), .out_sum_o(s3_sum), .out_approx_o(s3_oa)
    );

    csa_tree_pipe #(.WIDTH(24), .NUM_OPS(9), .APPROX_BITS(4)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s9_v), .in_ready_o(s9_rdy),
        .in_data_i(s9_d), .in_approx_i(1'b0), .out_valid_o(s9_ov),
        .out_ready_i(s9_ordy), .out_sum_o(s9_sum), .out_approx_o(s9_oa)
    );

    function automatic logic [191:0] rep(input logic [23:0] v);
        logic [191:0] d;
        for (int k = 0; k < 8; k++) d[k*24 +: 24] = v;
        return d;
    endfunction

    function automatic logic [26:0] ref_sum(input logic [191:0] d, input logic a);
        logic [26:0] s;
        logic [3:0]  o;
        logic [23:0] op;
        s = '0;
        o = '0;
        for (int k = 0; k < 8; k++) begin
            op = d[k*24 +: 24];
            if (a) begin
                s = s + (27'(op >> 4) << 4);
                o = o | op[3:0];
            end else begin
                s = s + 27'(op);
            end
        end
        return s | 27'(o);
    endfunction

    // One clock of the handshake scoreboard; entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [191:0] d, input logic a,
                       input logic ordy, input logic [26:0] e);
        logic        stall;
        logic [26:0] held_s;
        logic        held_a;
        logic [26:0] es;
        logic        ea;
        in_valid = v; in_data = d; in_approx = a; out_ready = ordy;
        #1;
        n_chk++;
        if (in_ready !== !(out_valid && !out_ready)) begin
            n_fail++;
            $display("FAIL in_ready: got %b required %b", in_ready, !(out_valid && !out_ready));
        end
        if (out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got sum %0h with no transaction outstanding", out_sum);
            end else begin
                es = exp_q.pop_front();
                ea = exp_a.pop_front();
                if (out_sum !== es || out_approx !== ea) begin
                    n_fail++;
                    $display("FAIL result: got %0h/%b required %0h/%b", out_sum, out_approx, es, ea);
                end
            end
        end
        if (v && in_ready) begin
            exp_q.push_back(e);
            exp_a.push_back(a);
        end
        stall  = out_valid && !out_ready;
        held_s = out_sum;
        held_a = out_approx;
        @(posedge clk); #1;
        if (stall) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_sum !== held_s || out_approx !== held_a) begin
                n_fail++;
                $display("FAIL stall_hold: got %b/%0h/%b required 1/%0h/%b",
                         out_valid, out_sum, out_approx, held_s, held_a);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++)
            if (exp_q.size() != 0) cyc(1'b0, '0, 1'b0, 1'b1, '0);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding required 0", exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_approx !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b s=%0h a=%b rdy=%b required 0/0/0/1",
                     out_valid, out_sum, out_approx, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        in_valid = 1'b1; in_approx = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k*24 +: 24] = 24'(k + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            n_chk++;
            if (out_sum !== '0) begin
                n_fail++;
                $display("FAIL pre_result_sum: got %0h required 0", out_sum);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_chk++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL latency: got %0d required 5", lat);
        end
        n_chk++;
        if (out_sum !== 27'd36 || out_approx !== 1'b0) begin
            n_fail++;
            $display("FAIL single_sum: got %0d/%b required 36/0", out_sum, out_approx);
        end
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consumed: got out_valid %b required 0", out_valid);
        end
    endtask

    task automatic test_max();
        cyc(1'b1, rep(24'hFFFFFF), 1'b0, 1'b1, 27'h7FFFFF8);
        drain();
    endtask

    task automatic test_approx();
        cyc(1'b1, rep(24'h00000F), 1'b1, 1'b1, 27'd15);
        cyc(1'b1, rep(24'h00000F), 1'b0, 1'b1, 27'd120);
        cyc(1'b1, rep(24'h00000F), 1'b1, 1'b1, 27'd15);
        cyc(1'b1, rep(24'h00000F), 1'b0, 1'b1, 27'd120);
        // high bits add exactly, low nibble ORs: 8*0x10 | (0x1|0x2|...)
        cyc(1'b1, {24'h18, 24'h17, 24'h16, 24'h15, 24'h14, 24'h13, 24'h12, 24'h11},
            1'b1, 1'b1, 27'h08F);
        drain();
    endtask

    task automatic test_stream();
        logic [191:0] d;
        logic         a;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 8; k++) d[k*24 +: 24] = 24'($urandom);
            a = 1'($urandom_range(0, 1));
            cyc(1'b1, d, a, 1'b1, ref_sum(d, a));
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [191:0] d;
        logic         a, v, r;
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 8; k++) d[k*24 +: 24] = 24'($urandom);
            a = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            cyc(v, d, a, r, ref_sum(d, a));
        end
        drain();
    endtask

    task automatic test_midreset();
        logic [191:0] d;
        for (int k = 0; k < 8; k++) d[k*24 +: 24] = 24'(k + 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, rep(24'(i + 5)), 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: got out_valid %b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_sum !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%0h required 0/0", out_valid, out_sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_a.delete();
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b1, '0);
        cyc(1'b1, d, 1'b0, 1'b1, 27'd36);
        drain();
    endtask

    task automatic test_sweep();
        int lat3, lat9;
        logic [25:0] sum3;
        logic [27:0] sum9;
        lat3 = 0; lat9 = 0; sum3 = '0; sum9 = '0;
        s3_d = {3{24'hFFFFFF}};
        s9_d = {9{24'hFFFFFF}};
        s3_v = 1'b1; s9_v = 1'b1;
        @(posedge clk); #1;
        s3_v = 1'b0; s9_v = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (s3_ov && lat3 == 0) begin lat3 = c; sum3 = s3_sum; end
            if (s9_ov && lat9 == 0) begin lat9 = c; sum9 = s9_sum; end
            @(posedge clk); #1;
        end
        n_chk++;
        if (lat3 != 2 || sum3 !== 26'd50331645) begin
            n_fail++;
            $display("FAIL sweep_n3: got lat %0d sum %0d required 2/50331645", lat3, sum3);
        end
        n_chk++;
        if (lat9 != 5 || sum9 !== 28'd150994935) begin
            n_fail++;
            $display("FAIL sweep_n9: got lat %0d sum %0d required 5/150994935", lat9, sum9);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_single();
        test_max();
        test_approx();
        test_stream();
        test_backpressure();
        test_midreset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
